// File: rtl/seq_divider.sv
// Iterative restoring divider with start/done handshake, signed mode and
// divide-by-zero / signed-overflow detection. One quotient bit per ITER cycle.
module seq_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [DIVIDEND_W-1:0] dividendin,
    input  logic [DIVISOR_W-1:0]  divisorin,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int CW = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DIVISOR_W:0]    rem_q, rem_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
    logic                  neg_dvd_q, neg_dvd_d;
    logic                  neg_dsr_q, neg_dsr_d;
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVISOR_W-1:0]  rmd_q, rmd_d;
    logic                  dz_q, dz_d;
    logic                  ov_q, ov_d;

    logic                  dz_hit_s;
    logic                  ov_hit_s;
    logic                  in_neg_dvd_s;
    logic                  in_neg_dsr_s;
    logic [DIVISOR_W+1:0]  shifted_s;
    logic [DIVISOR_W+1:0]  trial_s;

    assign in_neg_dvd_s = signed_mode & dividendin[DIVIDEND_W-1];
    assign in_neg_dsr_s = signed_mode & divisorin[DIVISOR_W-1];
    assign dz_hit_s     = (divisorin == {DIVISOR_W{1'b0}});
    assign ov_hit_s     = signed_mode
                        & (dividendin == {1'b1, {(DIVIDEND_W-1){1'b0}}})
                        & (divisorin == {DIVISOR_W{1'b1}});

    // The partial remainder never reaches the divisor, so the shifted value's MSB is 0 and trial_s MSB is the borrow.
    assign shifted_s = {rem_q, dvd_q[DIVIDEND_W-1]};
    assign trial_s   = shifted_s - {2'b00, dsr_q};

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (dz_hit_s || ov_hit_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ITER;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ITER: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the state register
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_ITER:  busy = 1'b1;
            S_FIX:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath next-value logic: capture, shift/subtract, sign fix-up
    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        neg_dvd_d = neg_dvd_q;
        neg_dsr_d = neg_dsr_q;
        quot_d    = quot_q;
        rmd_d     = rmd_q;
        dz_d      = dz_q;
        ov_d      = ov_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d     = CW'(DIVIDEND_W);
                    rem_d     = {(DIVISOR_W+1){1'b0}};
                    neg_dvd_d = in_neg_dvd_s;
                    neg_dsr_d = in_neg_dsr_s;
                    dvd_d     = in_neg_dvd_s ? ({DIVIDEND_W{1'b0}} - dividendin) : dividendin;
                    dsr_d     = in_neg_dsr_s ? ({DIVISOR_W{1'b0}} - divisorin) : divisorin;
                    if (dz_hit_s) begin
                        quot_d = {DIVIDEND_W{1'b1}};
                        rmd_d  = {DIVISOR_W{1'b0}};
                        dz_d   = 1'b1;
                        ov_d   = 1'b0;
                    end else if (ov_hit_s) begin
                        quot_d = {1'b1, {(DIVIDEND_W-1){1'b0}}};
                        rmd_d  = {DIVISOR_W{1'b0}};
                        dz_d   = 1'b0;
                        ov_d   = 1'b1;
                    end else begin
                        quot_d = quot_q;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_ITER: begin
                cnt_d = cnt_q - CW'(1);
                if (!trial_s[DIVISOR_W+1]) begin
                    rem_d = trial_s[DIVISOR_W:0];
                    dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b1};
                end else begin
                    rem_d = shifted_s[DIVISOR_W:0];
                    dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
                end
            end
            S_FIX: begin
                if (neg_dvd_q ^ neg_dsr_q) begin
                    quot_d = {DIVIDEND_W{1'b0}} - dvd_q;
                end else begin
                    quot_d = dvd_q;
                end
                if (neg_dvd_q) begin
                    rmd_d = {DIVISOR_W{1'b0}} - rem_q[DIVISOR_W-1:0];
                end else begin
                    rmd_d = rem_q[DIVISOR_W-1:0];
                end
                dz_d = 1'b0;
                ov_d = 1'b0;
            end
            S_DONE: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= {CW{1'b0}};
            rem_q     <= {(DIVISOR_W+1){1'b0}};
            dvd_q     <= {DIVIDEND_W{1'b0}};
            dsr_q     <= {DIVISOR_W{1'b0}};
            neg_dvd_q <= 1'b0;
            neg_dsr_q <= 1'b0;
            quot_q    <= {DIVIDEND_W{1'b0}};
            rmd_q     <= {DIVISOR_W{1'b0}};
            dz_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            neg_dvd_q <= neg_dvd_d;
            neg_dsr_q <= neg_dsr_d;
            quot_q    <= quot_d;
            rmd_q     <= rmd_d;
            dz_q      <= dz_d;
            ov_q      <= ov_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dz_q;
    assign overflow    = ov_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vectors, randomized ops against
// an arithmetic reference model, handshake/hold and mid-operation reset cases.
module tb_seq_divider;

    logic clk;
    logic reset;

    logic       start, signed_mode;
    logic [7:0] dividendin;
    logic [6:0] divisorin;
    logic       busy, done, div_by_zero, overflow;
    logic [7:0] quotient;
    logic [6:0] remainder;

    logic        start2, signed_mode2;
    logic [15:0] dividendin2;
    logic [11:0] divisorin2;
    logic        busy2, done2, div_by_zero2, overflow2;
    logic [15:0] quotient2;
    logic [11:0] remainder2;

    int checks = 0;
    int errors = 0;

    seq_divider dut (
        .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
        .dividendin(dividendin), .divisorin(divisorin), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    seq_divider #(.DIVIDEND_W(16), .DIVISOR_W(12)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .signed_mode(signed_mode2),
        .dividendin(dividendin2), .divisorin(divisorin2), .busy(busy2), .done(done2),
        .quotient(quotient2), .remainder(remainder2),
        .div_by_zero(div_by_zero2), .overflow(overflow2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sm;
        logic [7:0] a;
        logic [6:0] b;
        logic [7:0] q;
        logic [6:0] r;
        logic       dz;
        logic       ov;
        int         lat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division truncating toward zero, plus the special cases.
    function automatic void ref_div(input logic sm, input logic [7:0] a, input logic [6:0] b,
                                    output logic [7:0] q, output logic [6:0] r,
                                    output logic dz, output logic ov, output int lat);
        int ia, ib;
        if (sm) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
        end else begin
            ia = int'(a);
            ib = int'(b);
        end
        dz = 1'b0; ov = 1'b0; lat = 10;
        if (ib == 0) begin
            q = 8'hFF; r = 7'd0; dz = 1'b1; lat = 1;
        end else if (sm && ia == -128 && ib == -1) begin
            q = 8'h80; r = 7'd0; ov = 1'b1; lat = 1;
        end else begin
            q = 8'(ia / ib);
            r = 7'(ia % ib);
        end
    endfunction

    task automatic run_check(input string tag, input logic sm, input logic [7:0] a, input logic [6:0] b);
        logic [7:0] eq;
        logic [6:0] er;
        logic       edz, eov, busy_first;
        int         elat, lat;
        ref_div(sm, a, b, eq, er, edz, eov, elat);
        signed_mode = sm; dividendin = a; divisorin = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        busy_first = busy;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(elat));
        chk({tag, ".busy_after_start"}, {31'd0, busy_first}, {31'd0, (elat > 1)});
        chk({tag, ".quotient"}, {24'd0, quotient}, {24'd0, eq});
        chk({tag, ".remainder"}, {25'd0, remainder}, {25'd0, er});
        chk({tag, ".div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edz});
        chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, eov});
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int         gap;
        logic       held_ok, saw_done;
        logic       idle_busy, iter_busy;
        logic       sm;
        logic [7:0] a;
        logic [6:0] b;

        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int         gap;
        logic       held_ok, saw_done, idle_busy, iter_busy;
        logic       sm;
        logic [7:0] a;
        logic [6:0] b;

        vecs[0] = '{1'b0, 8'd200, 7'd7,    8'd28,  7'd4,  1'b0, 1'b0, 10};
        vecs[1] = '{1'b1, 8'h9C,  7'd7,    8'hF2,  7'h7E, 1'b0, 1'b0, 10};
        vecs[2] = '{1'b1, 8'd100, 7'h79,   8'hF2,  7'd2,  1'b0, 1'b0, 10};
        vecs[3] = '{1'b0, 8'd55,  7'd0,    8'hFF,  7'd0,  1'b1, 1'b0, 1};
        vecs[4] = '{1'b1, 8'h80,  7'h7F,   8'h80,  7'd0,  1'b0, 1'b1, 1};
        vecs[5] = '{1'b0, 8'd255, 7'd127,  8'd2,   7'd1,  1'b0, 1'b0, 10};
        vecs[6] = '{1'b1, 8'h80,  7'h40,   8'd2,   7'd0,  1'b0, 1'b0, 10};
        vecs[7] = '{1'b1, 8'h80,  7'd1,    8'h80,  7'd0,  1'b0, 1'b0, 10};
        vecs[8] = '{1'b0, 8'h80,  7'h7F,   8'd1,   7'd1,  1'b0, 1'b0, 10};

        start = 1'b0; signed_mode = 1'b0; dividendin = 8'd0; divisorin = 7'd0;
        start2 = 1'b0; signed_mode2 = 1'b0; dividendin2 = 16'd0; divisorin2 = 12'd0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.done", {31'd0, done}, 32'd0);
        chk("reset.quotient", {24'd0, quotient}, 32'd0);
        chk("reset.remainder", {25'd0, remainder}, 32'd0);
        chk("reset.flags", {30'd0, div_by_zero, overflow}, 32'd0);

        // Directed vectors: expectations written by hand, also cross-checked by the model.
        for (int i = 0; i < 9; i++) begin
            logic [7:0] mq; logic [6:0] mr; logic mdz, mov; int mlat;
            ref_div(vecs[i].sm, vecs[i].a, vecs[i].b, mq, mr, mdz, mov, mlat);
            chk("vec.model_q", {24'd0, mq}, {24'd0, vecs[i].q});
            chk("vec.model_r", {25'd0, mr}, {25'd0, vecs[i].r});
            run_check($sformatf("vec%0d", i), vecs[i].sm, vecs[i].a, vecs[i].b);
        end

        for (int i = 0; i < 250; i++) begin
            sm = 1'($urandom_range(0, 1));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 15) == 0) ? 7'd0 : 7'($urandom);
            if ($urandom_range(0, 20) == 0) begin
                sm = 1'b1; a = 8'h80; b = 7'h7F;
            end
            run_check($sformatf("rnd%0d", i), sm, a, b);
        end

        // Start held high across two operations; first results must hold until the second done.
        signed_mode = 1'b0; dividendin = 8'd255; divisorin = 7'd1; start = 1'b1;
        @(posedge clk); #1;
        gap = 1;
        while (!done && gap < 40) begin @(posedge clk); #1; gap++; end
        chk("hs1.latency", 32'(gap), 32'd10);
        chk("hs1.quotient", {24'd0, quotient}, 32'd255);
        chk("hs1.remainder", {25'd0, remainder}, 32'd0);
        dividendin = 8'd9; divisorin = 7'd3;
        gap = 0; held_ok = 1'b1; idle_busy = 1'b1; iter_busy = 1'b0;
        do begin
            @(posedge clk); #1;
            gap++;
            if (gap == 1) idle_busy = busy;
            if (gap == 2) iter_busy = busy;
            if (!done && (quotient !== 8'd255 || remainder !== 7'd0)) held_ok = 1'b0;
        end while (!done && gap < 40);
        start = 1'b0;
        chk("hs1.idle_after_done", {31'd0, idle_busy}, 32'd0);
        chk("hs1.busy_second", {31'd0, iter_busy}, 32'd1);
        chk("hs1.results_held", {31'd0, held_ok}, 32'd1);
        chk("hs1.gap", 32'(gap), 32'd11);
        chk("hs2.quotient", {24'd0, quotient}, 32'd3);
        chk("hs2.remainder", {25'd0, remainder}, 32'd0);
        @(posedge clk); #1;

        // Same handshake on the 16/12 instance.
        signed_mode2 = 1'b0; dividendin2 = 16'd60000; divisorin2 = 12'd4095; start2 = 1'b1;
        @(posedge clk); #1;
        gap = 1;
        while (!done2 && gap < 40) begin @(posedge clk); #1; gap++; end
        chk("w16a.latency", 32'(gap), 32'd18);
        chk("w16a.quotient", {16'd0, quotient2}, 32'd14);
        chk("w16a.remainder", {20'd0, remainder2}, 32'd2670);
        dividendin2 = 16'd1000; divisorin2 = 12'd7;
        gap = 0; held_ok = 1'b1;
        do begin
            @(posedge clk); #1;
            gap++;
            if (!done2 && (quotient2 !== 16'd14 || remainder2 !== 12'd2670)) held_ok = 1'b0;
        end while (!done2 && gap < 40);
        start2 = 1'b0;
        chk("w16b.results_held", {31'd0, held_ok}, 32'd1);
        chk("w16b.gap", 32'(gap), 32'd19);
        chk("w16b.quotient", {16'd0, quotient2}, 32'd142);
        chk("w16b.remainder", {20'd0, remainder2}, 32'd6);
        chk("w16b.flags", {30'd0, div_by_zero2, overflow2}, 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of ITER must abort without a done pulse.
        run_check("pre_reset", 1'b0, 8'd200, 7'd7);
        signed_mode = 1'b0; dividendin = 8'd201; divisorin = 7'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        chk("midreset.busy", {31'd0, busy}, 32'd0);
        chk("midreset.quotient", {24'd0, quotient}, 32'd0);
        chk("midreset.remainder", {25'd0, remainder}, 32'd0);
        chk("midreset.flags", {30'd0, div_by_zero, overflow}, 32'd0);
        saw_done = 1'b0;
        repeat (15) begin
            if (done || busy) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        chk("midreset.no_done", {31'd0, saw_done}, 32'd0);
        run_check("post_reset", 1'b0, 8'd201, 7'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
